// File: rtl/mux2x1_rr_arbiter.sv
// Round-robin select controller for a shared 2:1 mux. It grants one requester
// at a time, drives the mux select and registers the selected data onto y.
//
// Handshake: req0/req1 are level requests. gnt0/gnt1 rise one edge after a
// request and fall one edge after the request drops. While its gnt is high, a
// requester must hold its data stable. y/y_valid follow the grant by one edge.
module mux2x1_rr_arbiter #(
   parameter int WIDTH    = 1,
   parameter int MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] a1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             s,
   output logic [WIDTH-1:0] y,
   output logic             y_valid
);

   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [HW-1:0] hold_cnt;
   logic [HW-1:0] hold_nxt;
   logic          last;
   logic          last_nxt;
   logic          s_nxt;

   always_comb begin
      state_nxt = state;
      hold_nxt  = '0;
      last_nxt  = last;
      s_nxt     = s;
      case (state)
         IDLE: begin
            if (req0 && req1)  state_nxt = last ? GNT0 : GNT1;
            else if (req0)     state_nxt = GNT0;
            else if (req1)     state_nxt = GNT1;
         end
         GNT0: begin
            if (!req0)                              state_nxt = req1 ? GNT1 : IDLE;
            else if (req1 && hold_cnt == HOLD_LAST) state_nxt = GNT1;
            else hold_nxt = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
         end
         GNT1: begin
            if (!req1)                              state_nxt = req0 ? GNT0 : IDLE;
            else if (req0 && hold_cnt == HOLD_LAST) state_nxt = GNT0;
            else hold_nxt = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      // A fresh grant starts with hold_cnt=0 (default above) and records its owner.
      if (state_nxt != state) begin
         if (state_nxt == GNT0) begin
            last_nxt = 1'b0;
            s_nxt    = 1'b0;
         end else if (state_nxt == GNT1) begin
            last_nxt = 1'b1;
            s_nxt    = 1'b1;
         end
      end
   end

   assign gnt0 = (state == GNT0);
   assign gnt1 = (state == GNT1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         hold_cnt <= '0;
         last     <= 1'b1;
         s        <= 1'b0;
         y        <= '0;
         y_valid  <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         last     <= last_nxt;
         s        <= s_nxt;
         y_valid  <= gnt0 | gnt1;
         if (gnt0 | gnt1) y <= s ? a1 : a0;
      end
   end

endmodule

// File: tb/tb_mux2x1_rr_arbiter.sv
// Bench for mux2x1_rr_arbiter: a MAX_HOLD=4 and a MAX_HOLD=1 instance share
// stimulus; a cycle model predicts every output and a queue scoreboard compares.
module tb_mux2x1_rr_arbiter;

   localparam int WIDTH = 4;
   localparam int PW    = WIDTH + 4;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic             req0 = 1'b0;
   logic             req1 = 1'b0;
   logic [WIDTH-1:0] a0 = '0;
   logic [WIDTH-1:0] a1 = '0;

   logic             gnt0_a, gnt1_a, s_a, yv_a;
   logic [WIDTH-1:0] y_a;
   logic             gnt0_b, gnt1_b, s_b, yv_b;
   logic [WIDTH-1:0] y_b;

   mux2x1_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(4)) u_dut4 (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .a0(a0), .a1(a1),
      .gnt0(gnt0_a), .gnt1(gnt1_a), .s(s_a), .y(y_a), .y_valid(yv_a)
   );

   mux2x1_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(1)) u_dut1 (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .a0(a0), .a1(a1),
      .gnt0(gnt0_b), .gnt1(gnt1_b), .s(s_b), .y(y_b), .y_valid(yv_b)
   );

   // scoreboard
   logic [PW-1:0] exp_q4[$];
   logic [PW-1:0] exp_q1[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // model: owner -1 = idle; held = cycles the current owner has been granted
   int               m_owner[2];
   int               m_held[2];
   bit               m_last[2];
   bit               m_s[2];
   bit               m_yv[2];
   logic [WIDTH-1:0] m_y[2];
   int               m_max[2] = '{4, 1};

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_owner[i] = -1;
         m_held[i]  = 0;
         m_last[i]  = 1'b1;
         m_s[i]     = 1'b0;
         m_yv[i]    = 1'b0;
         m_y[i]     = '0;
      end
   endtask

   task automatic model_step(input int i);
      bit r[2];
      int nown;
      int k;
      r[0] = req0;
      r[1] = req1;
      m_yv[i] = (m_owner[i] != -1);
      if (m_owner[i] != -1) m_y[i] = m_s[i] ? a1 : a0;
      nown = m_owner[i];
      if (m_owner[i] == -1) begin
         if (r[0] && r[1]) nown = m_last[i] ? 0 : 1;
         else if (r[0])    nown = 0;
         else if (r[1])    nown = 1;
      end else begin
         k = m_owner[i];
         if (!r[k])                              nown = r[1-k] ? 1 - k : -1;
         else if (r[1-k] && m_held[i] >= m_max[i]) nown = 1 - k;
         else if (m_held[i] < m_max[i])          m_held[i]++;
      end
      if (nown != -1 && nown != m_owner[i]) begin
         m_held[i] = 1;
         m_last[i] = (nown == 1);
         m_s[i]    = (nown == 1);
      end
      m_owner[i] = nown;
   endtask

   function automatic logic [PW-1:0] model_pack(input int i);
      return {m_owner[i] == 0, m_owner[i] == 1, m_s[i], m_yv[i], m_y[i]};
   endfunction

   task automatic compare(input string pfx, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      check({pfx, "_gnt0"}, 32'(got[PW-1]), 32'(exp[PW-1]));
      check({pfx, "_gnt1"}, 32'(got[PW-2]), 32'(exp[PW-2]));
      check({pfx, "_s"},    32'(got[PW-3]), 32'(exp[PW-3]));
      check({pfx, "_yv"},   32'(got[PW-4]), 32'(exp[PW-4]));
      check({pfx, "_y"},    32'(got[WIDTH-1:0]), 32'(exp[WIDTH-1:0]));
      check({pfx, "_excl"}, 32'(got[PW-1] & got[PW-2]), 32'd0);
   endtask

   // driver: one clock edge with the inputs currently applied
   task automatic cycle();
      if (rst) model_reset();
      else for (int i = 0; i < 2; i++) model_step(i);
      exp_q4.push_back(model_pack(0));
      exp_q1.push_back(model_pack(1));
      @(posedge clk);
      @(negedge clk);
      check("sb4_depth", 32'(exp_q4.size()), 32'd1);
      check("sb1_depth", 32'(exp_q1.size()), 32'd1);
      if (exp_q4.size() > 0) compare("h4", {gnt0_a, gnt1_a, s_a, yv_a, y_a}, exp_q4.pop_front());
      if (exp_q1.size() > 0) compare("h1", {gnt0_b, gnt1_b, s_b, yv_b, y_b}, exp_q1.pop_front());
   endtask

   task automatic drive(input bit r0, input bit r1, input logic [WIDTH-1:0] d0,
                        input logic [WIDTH-1:0] d1, input int n);
      req0 = r0;
      req1 = r1;
      a0   = d0;
      a1   = d1;
      for (int c = 0; c < n; c++) cycle();
   endtask

   task automatic check_reset_outputs();
      compare("rst4", {gnt0_a, gnt1_a, s_a, yv_a, y_a}, '0);
      compare("rst1", {gnt0_b, gnt1_b, s_b, yv_b, y_b}, '0);
   endtask

   initial begin
      model_reset();
      #1 rst = 1'b1;
      #1 check_reset_outputs();
      drive(1'b0, 1'b0, '0, '0, 2);
      rst = 1'b0;

      // contention from reset: requester 0 first, 4/4 rotation vs. alternation
      drive(1'b1, 1'b1, 4'h0, 4'h1, 18);
      // handover: find GNT0 on the MAX_HOLD=4 instance, then drop req0
      for (int c = 0; c < 8 && !gnt0_a; c++) cycle();
      check("h4_in_gnt0", 32'(gnt0_a), 32'd1);
      drive(1'b0, 1'b1, 4'h0, 4'h1, 2);
      drive(1'b1, 1'b1, 4'h0, 4'h1, 8);
      // all requests off: y_valid falls, y holds
      drive(1'b0, 1'b0, 4'h5, 4'ha, 4);
      // single requester longer than MAX_HOLD
      drive(1'b0, 1'b1, 4'h3, 4'hc, 8);
      drive(1'b1, 1'b0, 4'h6, 4'h9, 7);
      drive(1'b1, 1'b1, 4'h6, 4'h9, 3);

      // random traffic
      for (int c = 0; c < 300; c++)
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)), 1);

      // async reset in the middle of GNT1
      drive(1'b0, 1'b1, 4'h2, 4'h7, 3);
      check("h4_in_gnt1", 32'(gnt1_a), 32'd1);
      rst = 1'b1;
      #1 check_reset_outputs();
      model_reset();
      drive(1'b0, 1'b1, 4'h2, 4'h7, 1);
      rst = 1'b0;
      drive(1'b1, 1'b1, 4'h4, 4'hb, 10);
      drive(1'b0, 1'b0, 4'h4, 4'hb, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
